// File: rtl/wb_check_pkg.sv
// Shared types for the writeback checker: checker state and the expected-entry record.
// Widths follow the rv32i core's register file.
package wb_check_pkg;

    localparam int WB_XLEN = 32;
    localparam int WB_AW   = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PASS,
        ST_FAIL
    } state_t;

    typedef struct packed {
        logic [WB_AW-1:0]   addr;
        logic [WB_XLEN-1:0] data;
    } exp_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; pushes when full and pops when empty are ignored.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; the count alone decides which slots are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/wb_check_unit.sv
// Compares retiring register-file writes, in order, against a preloaded list of expected writebacks.
// Sticky pass/fail verdict, a no-progress watchdog and first-mismatch diagnostics.
module wb_check_unit
    import wb_check_pkg::*;
#(
    parameter int XLEN    = WB_XLEN,
    parameter int AW      = WB_AW,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     exp_valid,
    output logic                     exp_ready,
    input  logic [AW-1:0]            exp_addr,
    input  logic [XLEN-1:0]          exp_data,
    input  logic                     start,
    input  logic                     wb_valid,
    input  logic [AW-1:0]            wb_addr,
    input  logic [XLEN-1:0]          wb_data,
    output logic                     done,
    output logic                     pass,
    output logic                     fail,
    output logic                     timeout,
    output logic [$clog2(DEPTH):0]   fail_idx,
    output logic [AW-1:0]            got_addr,
    output logic [XLEN-1:0]          got_data,
    output logic [AW-1:0]            want_addr,
    output logic [XLEN-1:0]          want_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int IW  = $clog2(DEPTH) + 1;
    localparam int EW  = AW + XLEN;
    localparam int WDW = $clog2(TIMEOUT + 1);

    state_t          r_state;
    logic            r_pass;
    logic            r_fail;
    logic            r_timeout;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   r_fail_idx;
    logic [AW-1:0]   r_got_addr;
    logic [XLEN-1:0] r_got_data;
    logic [AW-1:0]   r_want_addr;
    logic [XLEN-1:0] r_want_data;
    logic [WDW-1:0]  r_wdog;

    logic            w_push;
    logic            w_full;
    logic            w_empty;
    logic [IW-1:0]   w_count;
    logic [EW-1:0]   w_head;
    logic [AW-1:0]   w_head_addr;
    logic [XLEN-1:0] w_head_data;
    logic            w_qual;
    logic            w_match;

    assign exp_ready   = (r_state == ST_IDLE) && !w_full;
    assign w_push      = exp_valid && exp_ready;
    assign w_head_addr = w_head[EW-1:XLEN];
    assign w_head_data = w_head[XLEN-1:0];
    assign w_qual      = wb_valid && (wb_addr != '0);
    assign w_match     = (r_state == ST_RUN) && w_qual &&
                         (wb_addr == w_head_addr) && (wb_data == w_head_data);

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_match),
        .i_wdata ({exp_addr, exp_data}),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // A match outranks both a mismatch verdict and the watchdog on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_timeout   <= 1'b0;
            r_idx       <= '0;
            r_fail_idx  <= '0;
            r_got_addr  <= '0;
            r_got_data  <= '0;
            r_want_addr <= '0;
            r_want_data <= '0;
            r_wdog      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_idx  <= '0;
                        r_wdog <= '0;
                        if (w_empty && !w_push) begin
                            r_state <= ST_PASS;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_match) begin
                        r_idx  <= r_idx + 1'b1;
                        r_wdog <= '0;
                        if (w_count == IW'(1)) begin
                            r_state <= ST_PASS;
                            r_pass  <= 1'b1;
                        end
                    end else if (w_qual) begin
                        r_state     <= ST_FAIL;
                        r_fail      <= 1'b1;
                        r_fail_idx  <= r_idx;
                        r_got_addr  <= wb_addr;
                        r_got_data  <= wb_data;
                        r_want_addr <= w_head_addr;
                        r_want_data <= w_head_data;
                    end else if (r_wdog == WDW'(TIMEOUT - 1)) begin
                        r_state     <= ST_FAIL;
                        r_fail      <= 1'b1;
                        r_timeout   <= 1'b1;
                        r_fail_idx  <= r_idx;
                        r_got_addr  <= '0;
                        r_got_data  <= '0;
                        r_want_addr <= w_head_addr;
                        r_want_data <= w_head_data;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign pass      = r_pass;
    assign fail      = r_fail;
    assign done      = r_pass | r_fail;
    assign timeout   = r_timeout;
    assign fail_idx  = r_fail_idx;
    assign got_addr  = r_got_addr;
    assign got_data  = r_got_data;
    assign want_addr = r_want_addr;
    assign want_data = r_want_data;
    assign count     = w_count;

endmodule

// File: tb/tb_wb_check_unit.sv
// Directed bench for wb_check_unit (DEPTH=4, TIMEOUT=8) with hand-computed expectations.
module tb_wb_check_unit;
    import wb_check_pkg::*;

    localparam int XLEN    = 32;
    localparam int AW      = 5;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic            clk;
    logic            rst_n;
    logic            exp_valid;
    logic            exp_ready;
    logic [AW-1:0]   exp_addr;
    logic [XLEN-1:0] exp_data;
    logic            start;
    logic            wb_valid;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            done;
    logic            pass;
    logic            fail;
    logic            timeout;
    logic [2:0]      fail_idx;
    logic [AW-1:0]   got_addr;
    logic [XLEN-1:0] got_data;
    logic [AW-1:0]   want_addr;
    logic [XLEN-1:0] want_data;
    logic [2:0]      count;

    int totalChecks = 0;
    int badChecks   = 0;

    wb_check_unit #(
        .XLEN    (XLEN),
        .AW      (AW),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .exp_valid (exp_valid),
        .exp_ready (exp_ready),
        .exp_addr  (exp_addr),
        .exp_data  (exp_data),
        .start     (start),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .done      (done),
        .pass      (pass),
        .fail      (fail),
        .timeout   (timeout),
        .fail_idx  (fail_idx),
        .got_addr  (got_addr),
        .got_data  (got_data),
        .want_addr (want_addr),
        .want_data (want_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got=%0h want=%0h", tag, actual, expected);
        end
    endtask

    // Inputs change 1 ns after a rising edge, so checks made here see settled post-edge state.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst_n     = 1'b0;
        exp_valid = 1'b0;
        start     = 1'b0;
        wb_valid  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic applyPush(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        exp_valid = 1'b1;
        exp_addr  = a;
        exp_data  = d;
        tick();
        exp_valid = 1'b0;
    endtask

    task automatic applyStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic applyStimulus(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, ".done"}, 64'(done), 64'd0);
        checkOutput({tag, ".pass"}, 64'(pass), 64'd0);
        checkOutput({tag, ".fail"}, 64'(fail), 64'd0);
        checkOutput({tag, ".timeout"}, 64'(timeout), 64'd0);
        checkOutput({tag, ".fail_idx"}, 64'(fail_idx), 64'd0);
        checkOutput({tag, ".got"}, {27'd0, got_addr, got_data}, 64'd0);
        checkOutput({tag, ".want"}, {27'd0, want_addr, want_data}, 64'd0);
        checkOutput({tag, ".count"}, 64'(count), 64'd0);
        checkOutput({tag, ".exp_ready"}, 64'(exp_ready), 64'd1);
    endtask

    initial begin
        exp_entry_t e;
        exp_addr = '0;
        exp_data = '0;
        wb_addr  = '0;
        wb_data  = '0;

        // Reset state, then single-entry pass with verdict one cycle after the writeback
        applyReset();
        checkCleared("reset");
        applyPush(5'd1, 32'd19);
        checkOutput("t1.count", 64'(count), 64'd1);
        applyStart();
        checkOutput("t1.pass_before", 64'(pass), 64'd0);
        checkOutput("t1.exp_ready_run", 64'(exp_ready), 64'd0);
        applyStimulus(5'd1, 32'd19);
        checkOutput("t1.pass", 64'(pass), 64'd1);
        checkOutput("t1.fail", 64'(fail), 64'd0);
        checkOutput("t1.done", 64'(done), 64'd1);

        // Three entries with x0 writes interleaved
        applyReset();
        applyPush(5'd1, 32'd5);
        applyPush(5'd2, 32'd7);
        applyPush(5'd3, 32'd12);
        checkOutput("t2.count", 64'(count), 64'd3);
        applyStart();
        applyStimulus(5'd0, 32'd5);
        applyStimulus(5'd1, 32'd5);
        applyStimulus(5'd0, 32'd99);
        applyStimulus(5'd2, 32'd7);
        applyStimulus(5'd0, 32'd12);
        checkOutput("t2.pass_mid", 64'(pass), 64'd0);
        checkOutput("t2.fail_mid", 64'(fail), 64'd0);
        checkOutput("t2.count_mid", 64'(count), 64'd1);
        applyStimulus(5'd3, 32'd12);
        checkOutput("t2.pass", 64'(pass), 64'd1);
        checkOutput("t2.fail", 64'(fail), 64'd0);

        // Data mismatch on the first entry
        applyReset();
        applyPush(5'd4, 32'hDEADBEEF);
        applyStart();
        applyStimulus(5'd4, 32'hDEADBEEE);
        checkOutput("t3.fail", 64'(fail), 64'd1);
        checkOutput("t3.pass", 64'(pass), 64'd0);
        checkOutput("t3.timeout", 64'(timeout), 64'd0);
        checkOutput("t3.fail_idx", 64'(fail_idx), 64'd0);
        checkOutput("t3.got_addr", 64'(got_addr), 64'd4);
        checkOutput("t3.got_data", 64'(got_data), 64'hDEADBEEE);
        checkOutput("t3.want_addr", 64'(want_addr), 64'd4);
        checkOutput("t3.want_data", 64'(want_data), 64'hDEADBEEF);

        // Address mismatch on the second entry
        applyReset();
        applyPush(5'd1, 32'd1);
        applyPush(5'd2, 32'd2);
        applyStart();
        applyStimulus(5'd1, 32'd1);
        applyStimulus(5'd3, 32'd2);
        checkOutput("t3b.fail", 64'(fail), 64'd1);
        checkOutput("t3b.fail_idx", 64'(fail_idx), 64'd1);
        checkOutput("t3b.got_addr", 64'(got_addr), 64'd3);
        checkOutput("t3b.want_addr", 64'(want_addr), 64'd2);
        checkOutput("t3b.want_data", 64'(want_data), 64'd2);

        // Watchdog: fail exactly TIMEOUT edges after the start edge
        applyReset();
        applyPush(5'd9, 32'h1234);
        applyStart();
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        checkOutput("t4.fail_early", 64'(fail), 64'd0);
        tick();
        checkOutput("t4.fail", 64'(fail), 64'd1);
        checkOutput("t4.timeout", 64'(timeout), 64'd1);
        checkOutput("t4.want_addr", 64'(want_addr), 64'd9);
        checkOutput("t4.want_data", 64'(want_data), 64'h1234);
        checkOutput("t4.got_data", 64'(got_data), 64'd0);
        applyStimulus(5'd9, 32'h1234);
        applyStart();
        checkOutput("t4.sticky_fail", 64'(fail), 64'd1);
        checkOutput("t4.sticky_pass", 64'(pass), 64'd0);

        // Full FIFO drops the fifth entry, then all four match
        applyReset();
        for (int i = 0; i < 4; i++) applyPush(5'(i + 5), 32'(100 + i));
        checkOutput("t5.count_full", 64'(count), 64'd4);
        checkOutput("t5.exp_ready_full", 64'(exp_ready), 64'd0);
        applyPush(5'd20, 32'd999);
        checkOutput("t5.count_drop", 64'(count), 64'd4);
        applyStart();
        for (int i = 0; i < 3; i++) applyStimulus(5'(i + 5), 32'(100 + i));
        checkOutput("t5.pass_mid", 64'(pass), 64'd0);
        e.addr = 5'd8;
        e.data = 32'd103;
        applyStimulus(e.addr, e.data);
        checkOutput("t5.pass", 64'(pass), 64'd1);
        checkOutput("t5.fail", 64'(fail), 64'd0);

        // Empty list passes immediately
        applyReset();
        applyStart();
        checkOutput("t5e.pass", 64'(pass), 64'd1);
        checkOutput("t5e.done", 64'(done), 64'd1);

        // Push and start in the same cycle: the entry joins the run
        applyReset();
        exp_valid = 1'b1;
        exp_addr  = 5'd7;
        exp_data  = 32'd77;
        start     = 1'b1;
        tick();
        exp_valid = 1'b0;
        start     = 1'b0;
        checkOutput("t5s.pass_before", 64'(pass), 64'd0);
        checkOutput("t5s.count", 64'(count), 64'd1);
        applyStimulus(5'd7, 32'd77);
        checkOutput("t5s.pass", 64'(pass), 64'd1);

        // Reset mid-run clears everything; a fresh load then passes
        applyReset();
        applyPush(5'd1, 32'd11);
        applyPush(5'd2, 32'd22);
        applyStart();
        applyStimulus(5'd1, 32'd11);
        checkOutput("t6.count_mid", 64'(count), 64'd1);
        rst_n = 1'b0;
        tick();
        checkCleared("t6.reset");
        rst_n = 1'b1;
        applyPush(5'd6, 32'd66);
        applyStart();
        applyStimulus(5'd6, 32'd66);
        checkOutput("t6.pass", 64'(pass), 64'd1);
        checkOutput("t6.fail", 64'(fail), 64'd0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/wb_check_unit.md
# wb_check_unit

Synthesizable writeback checker that sits beside the rv32i core's register-file write port, for use in benches and FPGA bring-up. It generalises single fixed-time result checks into an ordered, parametrised list of expected writebacks: the list is loaded through a FIFO, then compared in program order against retiring writes. A watchdog counter detects hangs. The unit reports sticky pass/fail status plus diagnostics for the first mismatch.

## Interface
- `XLEN`, 32: data width of the register writeback.
- `AW`, 5: register address width.
- `DEPTH`, 16: expected-entry FIFO depth. Power of two, ≥2.
- `TIMEOUT`, 1024: maximum cycles between matched writebacks while running. Must be ≥1.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `exp_valid` in 1: expected-entry push request.
- `exp_ready` out 1: FIFO can accept an entry (not full and state is IDLE).
- `exp_addr` in AW: expected destination register.
- `exp_data` in XLEN: expected write value.
- `start` in 1: begin checking (one-cycle pulse).
- `wb_valid` in 1: core register-file write enable.
- `wb_addr` in AW: core write address.
- `wb_data` in XLEN: core write data.
- `done` out 1: sticky; check finished.
- `pass` out 1: sticky; all entries matched.
- `fail` out 1: sticky; mismatch or timeout.
- `timeout` out 1: sticky; failure cause was the watchdog.
- `fail_idx` out $clog2(DEPTH)+1: index of the failing entry.
- `got_addr` out AW: observed address at the mismatch.
- `got_data` out XLEN: observed data at the mismatch.
- `want_addr` out AW: expected address at the mismatch.
- `want_data` out XLEN: expected data at the mismatch.
- `count` out $clog2(DEPTH)+1: number of entries currently held in the FIFO.

## Operation
- States: IDLE, RUN, PASS, FAIL.
- IDLE: a push is accepted when `exp_valid && exp_ready`; the entry is written at the tail. `start` moves the unit to RUN.
  - `start` with `count==0` goes directly to PASS (empty list passes trivially).
- RUN: accepts no pushes. A write counts as qualified when `wb_valid` is high and `wb_addr != 0`; writes to x0 are ignored.
  - A qualified write is compared with the head entry on both address and data.
  - Match: pop the head, increment the match index, clear the watchdog. If this was the last entry, go to PASS.
  - Mismatch: capture the diagnostics and go to FAIL.
- Watchdog: counts cycles in RUN with no match. When the count reaches `TIMEOUT`, go to FAIL with `timeout=1`. Diagnostics then hold want = head entry and got = 0.
- PASS and FAIL are terminal until reset. Qualified writes arriving in these states are ignored, and so are further `start` pulses.
- `start` asserted while in RUN is ignored.

## Timing
- Reset values: state IDLE, FIFO empty, `count=0`, `exp_ready=1`, and all status and diagnostic outputs 0.
- Reset takes effect only at a clock edge with `rst_n` low. Reset mid-RUN discards the FIFO contents and all status.
- Push latency: an entry pushed at edge N is counted in `count` after edge N.
- Status latency: the compare is made at edge N on the current head. `done`, `pass` and `fail` are visible after edge N, so the verdict arrives one cycle after the final writeback.
- Same-cycle `exp_valid` and `start` in IDLE: the push is accepted and included in the run.
- Full FIFO: `exp_ready=0`; `exp_valid` is ignored and the entry is dropped, with no error raised.
- FIFO pointers wrap modulo DEPTH. `count` distinguishes full from empty.
- Watchdog: with no qualified match after `start` at edge S, `fail` and `timeout` assert after edge S+TIMEOUT.
  - A match on that same edge takes priority over the timeout.
- `done = pass | fail`, driven combinationally from registered state.

## Structure
- Shared package `wb_check_pkg`: a state enum typedef and a packed struct `exp_entry_t` holding {addr, data}.
  - The package is parametrised through localparams matching the core's XLEN and AW.
- One sub-module: `sync_fifo`, parametrised by width and depth, with push, pop, full, empty and count. It is reusable elsewhere in the core.
- The FSM, watchdog and diagnostic registers stay in `wb_check_unit`.

## Test plan
- Push {x1=19}, start, drive wb {x1,19} → `pass=1`, `fail=0`, `done=1` one cycle later.
- Push {x1=5},{x2=7},{x3=12}; drive x0 writes between matching writes → x0 writes are ignored; `pass=1` after the third.
- Push {x4=0xDEADBEEF}, drive {x4,0xDEADBEEE} → `fail=1`, `timeout=0`, `fail_idx=0`, `got_data=0xDEADBEEE`, `want_data=0xDEADBEEF`.
- `TIMEOUT=8`, push one entry, start, no wb → `fail=1` and `timeout=1` exactly 8 cycles after start.
- DEPTH=4: push 5 entries → `exp_ready=0` after 4 and the fifth is dropped; start and match 4 → pass. Start with an empty FIFO → immediate pass.
- Assert `rst_n=0` mid-RUN → all outputs 0 and `exp_ready=1`; a new load and run then passes.
